// File: rtl/log2_sum_accumulator.sv
// Streaming log-domain accumulator: folds a packet of unsigned integer
// exponents into an approximation of log2(sum 2^x_i) using the serial
// two-operand rule max(a,b) + 2^-|a-b|, with FRAC_W fractional bits.
module log2_sum_accumulator #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_sum,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_cnt_sat
);

    localparam int AW = EXP_W + 1 + FRAC_W;

    // Largest integer distance that still yields a non-zero correction.
    localparam logic [AW-1:0] FRAC_LIM = AW'(FRAC_W);
    // Correction for equal operands: exactly 1.0 in fixed point.
    localparam logic [AW-1:0] ONE_FX   = AW'(1) << FRAC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       acc_reg, acc_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                cnt_sat_reg, cnt_sat_next;
    logic [AW-1:0]       out_sum_reg;
    logic [CNT_W-1:0]    out_count_reg;
    logic                out_cnt_sat_reg;
    logic                load_out;

    logic                accept;
    logic [AW-1:0]       x_ext;
    logic [AW-1:0]       diff;
    logic [AW-1:0]       d_int;
    logic [AW-1:0]       max_ax;
    logic [AW-1:0]       corr;
    logic [AW-1:0]       acc_upd;

    // Ready is purely a function of state so it drops the cycle DONE is entered.
    assign in_ready  = !rst && (state_reg != DONE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign out_sum     = out_sum_reg;
    assign out_count   = out_count_reg;
    assign out_cnt_sat = out_cnt_sat_reg;

    // Two-operand log-add datapath: max plus a shifted power-of-two correction.
    always_comb begin
        x_ext  = {1'b0, in_exp, {FRAC_W{1'b0}}};
        if (acc_reg >= x_ext) begin
            diff   = acc_reg - x_ext;
            max_ax = acc_reg;
        end else begin
            diff   = x_ext - acc_reg;
            max_ax = x_ext;
        end
        d_int = diff >> FRAC_W;
        if (d_int > FRAC_LIM) begin
            corr = '0;
        end else begin
            corr = ONE_FX >> d_int;
        end
        // Cannot overflow AW bits: the integer part grows at most 1 per beat.
        acc_upd = max_ax + corr;
    end

    // Next-state, accumulator and counter update logic.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        count_next   = count_reg;
        cnt_sat_next = cnt_sat_reg;
        load_out     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    acc_next     = x_ext;
                    count_next   = CNT_ONE;
                    cnt_sat_next = 1'b0;
                    if (in_last) begin
                        state_next = DONE;
                        load_out   = 1'b1;
                    end else begin
                        state_next = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_next = acc_upd;
                    if (count_reg == CNT_MAX) begin
                        cnt_sat_next = 1'b1;
                    end else begin
                        count_next = count_reg + CNT_ONE;
                    end
                    if (in_last) begin
                        state_next = DONE;
                        load_out   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, accumulator and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            count_reg   <= '0;
            cnt_sat_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            cnt_sat_reg <= cnt_sat_next;
        end
    end

    // Result registers: captured with the final beat, held until the next packet ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum_reg     <= '0;
            out_count_reg   <= '0;
            out_cnt_sat_reg <= 1'b0;
        end else if (load_out) begin
            out_sum_reg     <= acc_next;
            out_count_reg   <= count_next;
            out_cnt_sat_reg <= cnt_sat_next;
        end
    end

endmodule

// File: tb/tb_log2_sum_accumulator.sv
// Scoreboard bench for log2_sum_accumulator: stimulus pushes hand-computed
// results into a queue, a negedge monitor pops and compares on each handshake.
module tb_log2_sum_accumulator;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 4;
    localparam int CNT_W  = 8;
    localparam int SW     = EXP_W + 1 + FRAC_W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_exp;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_cnt_sat;

    typedef struct packed {
        logic [SW-1:0]    sum;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    log2_sum_accumulator #(
        .EXP_W (EXP_W),
        .FRAC_W(FRAC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_exp     (in_exp),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_cnt_sat(out_cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [SW-1:0] s, input logic [CNT_W-1:0] c, input logic sat);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.sat = sat;
        sb_q.push_back(e);
    endtask

    // Drive one beat (called 1 time unit after a rising edge) and wait until it is taken.
    task automatic send(input logic [EXP_W-1:0] e, input logic last);
        int budget;
        in_valid = 1'b1;
        in_exp   = e;
        in_last  = last;
        budget   = 0;
        while (!in_ready && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", budget);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed output handshake is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: sum=0x%0h count=%0d with empty scoreboard, expected no output",
                         out_sum, out_count);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_count", 32'(out_count), 32'(e.cnt));
                check("out_cnt_sat", 32'(out_cnt_sat), 32'(e.sat));
                $display("output: sum=0x%03h count=%0d sat=%0d", out_sum, out_count, out_cnt_sat);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_exp    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_cnt_sat", 32'(out_cnt_sat), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 5,5 -> 6.0, valid the cycle after the last beat, then one bubble
        expect_out(13'h060, 8'd2, 1'b0);
        send(8'd5, 1'b0);
        send(8'd5, 1'b1);
        check("p55_latency_valid", 32'(out_valid), 32'd1);
        check("p55_in_ready_low", 32'(in_ready), 32'd0);
        idle_cycle();
        check("p55_bubble_in_ready", 32'(in_ready), 32'd1);
        check("p55_valid_cleared", 32'(out_valid), 32'd0);

        // 5,5,5,5 -> 0x50, 0x60, 0x68, 0x70
        expect_out(13'h070, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(8'd5, (i == 3));
        idle_cycle();

        // 10,3 and 3,10: distance 7 exceeds FRAC_W, no correction
        expect_out(13'h0A0, 8'd2, 1'b0);
        send(8'd10, 1'b0);
        send(8'd3, 1'b1);
        idle_cycle();
        expect_out(13'h0A0, 8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd10, 1'b1);
        idle_cycle();

        // Single beat 255 with downstream back-pressure for 5 cycles
        out_ready = 1'b0;
        expect_out(13'hFF0, 8'd1, 1'b0);
        send(8'd255, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_sum", 32'(out_sum), 32'hFF0);
            check("hold_out_count", 32'(out_count), 32'd1);
            idle_cycle();
        end
        out_ready = 1'b1;
        idle_cycle();
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);

        // 300 zeros with gaps. By hand: 0,16,24,32,36,40,44,48, then +2 per beat
        // to 64 (beat 16), +1 per beat to 80 (beat 32), after which the distance
        // exceeds FRAC_W and A stays at 0x050. Count saturates at 255.
        expect_out(13'h050, 8'd255, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (i % 7 == 3) idle_cycle();
            send(8'd0, (i == 299));
        end
        idle_cycle();

        // Reset after 3 beats discards the packet and clears the result registers
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        check("midrst_out_cnt_sat", 32'(out_cnt_sat), 32'd0);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end
        expect_out(13'h070, 8'd1, 1'b0);
        send(8'd7, 1'b1);
        check("after_rst_valid", 32'(out_valid), 32'd1);

        repeat (4) idle_cycle();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
